// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the mips_data_memory arbiter:
//   ADDR_W / DATA_W : memory word-address and data widths
//   state_e         : arbiter sequencer states (IDLE, ACCESS, DONE)
//   idx_width()     : bits needed to hold a requester index
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mips_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // A two-port arbiter still needs one index bit, so clamp the minimum at 1.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mips_rr_picker.sv
// -----------------------------------------------------------------------------
// mips_rr_picker
// Combinational round-robin picker. Searches the unmasked requests starting
// one above the most recent winner and wrapping modulo N_REQ.
// Ports:
//   req_i   : per-port request
//   mask_i  : per-port exclusion (1 = not eligible this cycle)
//   last_i  : index of the most recent winner
//   win_o   : one-hot winner (all zero when nothing is eligible)
//   found_o : a winner exists
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mips_rr_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]                           req_i,
  input  logic [N_REQ-1:0]                           mask_i,
  input  logic [mips_mem_pkg::idx_width(N_REQ)-1:0]  last_i,
  output logic [N_REQ-1:0]                           win_o,
  output logic                                       found_o
);
  import mips_mem_pkg::*;

  localparam int IDX_W = idx_width(N_REQ);

  logic [N_REQ-1:0] eff_s;
  logic [IDX_W-1:0] idx_s;
  logic             hit_s;

  // Rotating priority search: the first eligible port after last_i wins.
  always_comb begin
    eff_s   = req_i & ~mask_i;
    win_o   = '0;
    found_o = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s        = IDX_W'((int'(last_i) + k) % N_REQ);
      hit_s        = eff_s[idx_s] & ~found_o;
      win_o[idx_s] = win_o[idx_s] | hit_s;
      found_o      = found_o | hit_s;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_mem_arbiter
// Round-robin arbiter/sequencer sharing one single-ported mips_data_memory
// between N_REQ requesters. One transaction = IDLE/DONE arbitration, one
// ACCESS cycle driving the memory, one DONE cycle pulsing ack.
// Ports:
//   clock, reset_n         : clock, synchronous active-low reset
//   req/we/lock/addr/wdata : per-port held request, direction, keep-grant
//                            hint, packed address and packed write data
//   gnt, ack               : one-hot owner, one-cycle completion pulse
//   rdata, busy            : read result (held between acks), in-flight flag
//   mem_address, mem_write_data, signal_mem_write, signal_mem_read,
//   mem_read_data          : memory-side connections
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mips_mem_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DATA_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_write_data,
  output logic                      signal_mem_write,
  output logic                      signal_mem_read,
  input  logic [DATA_W-1:0]         mem_read_data
);
  import mips_mem_pkg::*;

  localparam int               IDX_W    = idx_width(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              we_q, lock_q, lock_hold_q;
  logic [N_REQ-1:0]  gnt_q, ack_q;

  logic [N_REQ-1:0]  owner_oh_s, pick_mask_s, win_oh_s;
  logic              pick_found_s, lock_grant_s, grant_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic              win_we_s, win_lock_s;

  mips_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i   (req),
    .mask_i  (pick_mask_s),
    .last_i  (last_q),
    .win_o   (win_oh_s),
    .found_o (pick_found_s)
  );

  // Decode the registered owner index to one-hot.
  always_comb begin
    owner_oh_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_oh_s[i] = (owner_q == IDX_W'(i));
    end
  end

  // Eligibility mask: a lock holder gets the first IDLE cycle to itself,
  // an unlocked owner is masked in DONE, and a locked owner's DONE grants
  // nobody so its follow-up request is not overtaken.
  always_comb begin
    pick_mask_s  = {N_REQ{1'b1}};
    lock_grant_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lock_hold_q && (|(req & owner_oh_s))) begin
          pick_mask_s  = ~owner_oh_s;
          lock_grant_s = 1'b1;
        end else begin
          pick_mask_s  = '0;
          lock_grant_s = 1'b0;
        end
      end
      ST_DONE: begin
        if (lock_q) begin
          pick_mask_s = {N_REQ{1'b1}};
        end else begin
          pick_mask_s = owner_oh_s;
        end
      end
      ST_ACCESS: pick_mask_s = {N_REQ{1'b1}};
      default:   pick_mask_s = {N_REQ{1'b1}};
    endcase
  end

  assign grant_s = pick_found_s & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Select the winning port's address, data, direction and lock hint.
  always_comb begin
    win_idx_s   = '0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    win_we_s    = 1'b0;
    win_lock_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      win_idx_s   = win_idx_s   | ({IDX_W{win_oh_s[i]}}  & IDX_W'(i));
      win_addr_s  = win_addr_s  | ({ADDR_W{win_oh_s[i]}} & addr[i*ADDR_W +: ADDR_W]);
      win_wdata_s = win_wdata_s | ({DATA_W{win_oh_s[i]}} & wdata[i*DATA_W +: DATA_W]);
      win_we_s    = win_we_s    | (win_oh_s[i] & we[i]);
      win_lock_s  = win_lock_s  | (win_oh_s[i] & lock[i]);
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE: begin
        if (pick_found_s) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: strobes only in ACCESS, and gated by reset_n so an edge
  // with reset asserted can never write the memory.
  always_comb begin
    signal_mem_write = 1'b0;
    signal_mem_read  = 1'b0;
    busy             = 1'b0;
    if (reset_n && (state_q == ST_ACCESS)) begin
      signal_mem_write = we_q;
      signal_mem_read  = ~we_q;
    end else begin
      signal_mem_write = 1'b0;
      signal_mem_read  = 1'b0;
    end
    case (state_q)
      ST_ACCESS: busy = 1'b1;
      ST_DONE:   busy = 1'b1;
      ST_IDLE:   busy = 1'b0;
      default:   busy = 1'b0;
    endcase
  end

  // Transaction registers: capture the winner on grant, retire at the end
  // of ACCESS (ack pulse and read-data capture), track the lock hand-off.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner_q     <= '0;
      last_q      <= LAST_RST;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_hold_q <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
    end else begin
      ack_q <= '0;
      if (grant_s) begin
        owner_q <= win_idx_s;
        addr_q  <= win_addr_s;
        wdata_q <= win_wdata_s;
        we_q    <= win_we_s;
        lock_q  <= win_lock_s;
        gnt_q   <= win_oh_s;
        // A locked re-grant keeps the round-robin position untouched.
        if (!lock_grant_s) begin
          last_q <= win_idx_s;
        end else begin
          last_q <= last_q;
        end
      end else if (state_q != ST_ACCESS) begin
        gnt_q <= '0;
      end else begin
        gnt_q <= gnt_q;
      end
      if (state_q == ST_ACCESS) begin
        ack_q <= owner_oh_s;
        if (!we_q) begin
          rdata_q <= mem_read_data;
        end else begin
          rdata_q <= rdata_q;
        end
      end else begin
        ack_q <= '0;
      end
      // The lock survives exactly one IDLE cycle after a locked DONE.
      if (state_q == ST_DONE) begin
        lock_hold_q <= lock_q & ~grant_s;
      end else if (state_q == ST_IDLE) begin
        lock_hold_q <= 1'b0;
      end else begin
        lock_hold_q <= lock_hold_q;
      end
    end
  end

  assign gnt            = gnt_q;
  assign ack            = ack_q;
  assign rdata          = rdata_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule
